// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel arbiter: screen geometry, colour/address
// widths, coordinate field layout and the black colour used for erase.
package vga_pkg;

    localparam int X_MAX    = 160;
    localparam int Y_MAX    = 120;
    localparam int COLOUR_W = 9;
    localparam int ADDR_W   = 15;

    // Packed coordinate is {x[7:0], y[6:0]}
    localparam int COORD_W  = 15;
    localparam int X_W      = 8;
    localparam int X_LSB    = 7;
    localparam int Y_W      = 7;

    localparam logic [COLOUR_W-1:0] BLACK = '0;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_pixel_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping modulo NUM_SRC. The pointer register lives in the parent.
module rr_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = ptr_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               found
);

    logic [31:0] pos;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NUM_SRC) begin
                pos = pos - NUM_SRC;
            end
            if (!found && req[pos[PTR_W-1:0]]) begin
                found                  = 1'b1;
                winner                 = pos[PTR_W-1:0];
                grant[pos[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pixel_arbiter.sv
// Merges NUM_SRC pixel sources onto the VGA write port with round-robin
// arbitration and a 2-stage pipeline; VGA_BG_ERASE_EN enables background-RAM erase.
module vga_pixel_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int X_MAX    = vga_pkg::X_MAX,
    parameter int Y_MAX    = vga_pkg::Y_MAX,
    parameter int COLOUR_W = vga_pkg::COLOUR_W,
    parameter int ADDR_W   = vga_pkg::ADDR_W
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [NUM_SRC*COORD_W-1:0]   src_coord,
    input  logic [NUM_SRC*COLOUR_W-1:0]  src_colour,
    input  logic [NUM_SRC-1:0]           src_erase,
    output logic [ADDR_W-1:0]            bg_addr,
    input  logic [COLOUR_W-1:0]          bg_q,
    output logic [COORD_W-1:0]           coordinates,
    output logic [COLOUR_W-1:0]          colours,
    output logic                         VGA_write_enable,
    output logic [7:0]                   drop_count,
    output logic                         busy
);

    localparam int PTR_W = ptr_width(NUM_SRC);

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    winner;
    logic [NUM_SRC-1:0]  grant;
    logic                any_req;
    logic                accept;

    logic [COORD_W-1:0]  sel_coord;
    logic [COLOUR_W-1:0] sel_colour;
    logic                sel_erase;
    logic                sel_in_range;

    logic                s1_valid, s1_erase, s1_in_range;
    logic [COORD_W-1:0]  s1_coord;
    logic [COLOUR_W-1:0] s1_colour;
    logic                s2_valid, s2_erase, s2_in_range;
    logic [COORD_W-1:0]  s2_coord;
    logic [COLOUR_W-1:0] s2_colour;
    logic [COLOUR_W-1:0] out_colour;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req    (src_valid),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner),
        .found  (any_req)
    );

    assign src_ready = resetn ? '0 : grant;
    assign accept    = any_req & ~resetn;

    always_comb begin
        sel_coord  = '0;
        sel_colour = '0;
        sel_erase  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_coord  = src_coord[i*COORD_W +: COORD_W];
                sel_colour = src_colour[i*COLOUR_W +: COLOUR_W];
                sel_erase  = src_erase[i];
            end
        end
        sel_in_range = (32'(sel_coord[COORD_W-1:X_LSB]) < X_MAX) &&
                       (32'(sel_coord[Y_W-1:0]) < Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (winner == PTR_W'(NUM_SRC - 1)) ? '0 : winner + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            s1_valid    <= 1'b0;
            s1_coord    <= '0;
            s1_colour   <= '0;
            s1_erase    <= 1'b0;
            s1_in_range <= 1'b0;
            s2_valid    <= 1'b0;
            s2_coord    <= '0;
            s2_colour   <= '0;
            s2_erase    <= 1'b0;
            s2_in_range <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_coord    <= sel_coord;
                s1_colour   <= sel_colour;
                s1_erase    <= sel_erase;
                s1_in_range <= sel_in_range;
            end
            s2_valid    <= s1_valid;
            s2_coord    <= s1_coord;
            s2_colour   <= s1_colour;
            s2_erase    <= s1_erase;
            s2_in_range <= s1_in_range;
        end
    end

`ifdef VGA_BG_ERASE_EN
    // RAM samples this address on the stage-2 edge, so bg_q lines up with stage 2
    assign bg_addr = ADDR_W'(32'(s1_coord[Y_W-1:0]) * X_MAX +
                             32'(s1_coord[COORD_W-1:X_LSB]));

    always_comb begin
        out_colour = s2_erase ? bg_q : s2_colour;
    end
`else
    logic unused_bg;

    assign bg_addr   = '0;
    assign unused_bg = ^bg_q;

    always_comb begin
        out_colour = s2_erase ? COLOUR_W'(BLACK) : s2_colour;
    end
`endif

    always_ff @(posedge clk) begin
        if (resetn) begin
            coordinates      <= '0;
            colours          <= '0;
            VGA_write_enable <= 1'b0;
            drop_count       <= '0;
        end else begin
            coordinates      <= s2_coord;
            colours          <= out_colour;
            VGA_write_enable <= s2_valid & s2_in_range;
            if (s2_valid && !s2_in_range && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign busy = s1_valid | s2_valid | VGA_write_enable;

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// Directed self-checking bench for vga_pixel_arbiter (NUM_SRC=4); honours VGA_BG_ERASE_EN.
module tb_vga_pixel_arbiter;

    localparam int N = 4;

`ifdef VGA_BG_ERASE_EN
    localparam logic [14:0] EXP_ADDR  = 15'd323;
    localparam logic [8:0]  EXP_ERASE = 9'h0AA;
`else
    localparam logic [14:0] EXP_ADDR  = 15'd0;
    localparam logic [8:0]  EXP_ERASE = 9'h000;
`endif

    logic           clk = 1'b0;
    logic           resetn = 1'b1;
    logic [N-1:0]   src_valid = '0;
    logic [N-1:0]   src_ready;
    logic [N*15-1:0] src_coord = '0;
    logic [N*9-1:0] src_colour = '0;
    logic [N-1:0]   src_erase = '0;
    logic [14:0]    bg_addr;
    logic [8:0]     bg_q;
    logic [14:0]    coordinates;
    logic [8:0]     colours;
    logic           VGA_write_enable;
    logic [7:0]     drop_count;
    logic           busy;

    int checks = 0;
    int errors = 0;

    vga_pixel_arbiter #(
        .NUM_SRC  (N),
        .X_MAX    (160),
        .Y_MAX    (120),
        .COLOUR_W (9),
        .ADDR_W   (15)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .src_coord        (src_coord),
        .src_colour       (src_colour),
        .src_erase        (src_erase),
        .bg_addr          (bg_addr),
        .bg_q             (bg_q),
        .coordinates      (coordinates),
        .colours          (colours),
        .VGA_write_enable (VGA_write_enable),
        .drop_count       (drop_count),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Background RAM model: one-cycle read latency
    always @(posedge clk) bg_q <= (bg_addr == 15'd323) ? 9'h0AA : 9'h155;

    task automatic set_src(input int i, input int x, input int y,
                           input logic [8:0] col, input logic er);
        src_coord[i*15 +: 15] = {x[7:0], y[6:0]};
        src_colour[i*9 +: 9]  = col;
        src_erase[i]          = er;
    endtask

    task automatic do_reset;
        src_valid = '0;
        src_erase = '0;
        resetn    = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < N; i++) set_src(i, 1, 1, 9'h1FF, 1'b0);
        resetn    = 1'b1;
        src_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (src_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", src_ready); end
        checks++; if (VGA_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", VGA_write_enable); end
        checks++; if (coordinates !== 15'd0) begin errors++; $display("FAIL reset_coord got %h exp 0", coordinates); end
        checks++; if (colours !== 9'd0) begin errors++; $display("FAIL reset_colour got %h exp 0", colours); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        src_valid = '0;
        resetn    = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        set_src(0, 10, 5, 9'h1C0, 1'b0);
        src_valid = 4'b0001;
        #1;
        checks++; if (src_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", src_ready); end
        @(negedge clk);
        src_valid = '0;
        #1;
        checks++; if (VGA_write_enable !== 1'b0) begin errors++; $display("FAIL single_we_early1 got %b exp 0", VGA_write_enable); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        @(negedge clk);
        checks++; if (VGA_write_enable !== 1'b0) begin errors++; $display("FAIL single_we_early2 got %b exp 0", VGA_write_enable); end
        @(negedge clk);
        checks++; if (VGA_write_enable !== 1'b1) begin errors++; $display("FAIL single_we got %b exp 1", VGA_write_enable); end
        checks++; if (coordinates !== {8'd10, 7'd5}) begin errors++; $display("FAIL single_coord got %h exp %h", coordinates, {8'd10, 7'd5}); end
        checks++; if (colours !== 9'h1C0) begin errors++; $display("FAIL single_colour got %h exp 1c0", colours); end
        @(negedge clk);
        checks++; if (VGA_write_enable !== 1'b0) begin errors++; $display("FAIL single_we_after got %b exp 0", VGA_write_enable); end
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_g;
        logic [14:0] exp_c;
        int          s;
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 20 + i, 10 + i, 9'h100 + 9'(i), 1'b0);
        src_valid = 4'b1111;
        for (int n = 0; n < 12; n++) begin
            if (n == 8) src_valid = '0;
            #1;
            if (n < 8) begin
                exp_g = 4'b0001 << (n % 4);
                checks++; if (src_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", n, src_ready, exp_g); end
            end
            if (n >= 3 && n <= 10) begin
                s     = (n - 3) % 4;
                exp_c = {8'(20 + s), 7'(10 + s)};
                checks++; if (VGA_write_enable !== 1'b1) begin errors++; $display("FAIL rr_we[%0d] got %b exp 1", n, VGA_write_enable); end
                checks++; if (coordinates !== exp_c) begin errors++; $display("FAIL rr_coord[%0d] got %h exp %h", n, coordinates, exp_c); end
            end else begin
                checks++; if (VGA_write_enable !== 1'b0) begin errors++; $display("FAIL rr_we_idle[%0d] got %b exp 0", n, VGA_write_enable); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_erase;
        do_reset();
        set_src(2, 3, 2, 9'h1FF, 1'b1);
        src_valid = 4'b0100;
        #1;
        checks++; if (src_ready !== 4'b0100) begin errors++; $display("FAIL erase_ready got %b exp 0100", src_ready); end
        @(negedge clk);
        src_valid = '0;
        src_erase = '0;
        #1;
        checks++; if (bg_addr !== EXP_ADDR) begin errors++; $display("FAIL erase_bg_addr got %0d exp %0d", bg_addr, EXP_ADDR); end
        repeat (2) @(negedge clk);
        checks++; if (VGA_write_enable !== 1'b1) begin errors++; $display("FAIL erase_we got %b exp 1", VGA_write_enable); end
        checks++; if (coordinates !== {8'd3, 7'd2}) begin errors++; $display("FAIL erase_coord got %h exp %h", coordinates, {8'd3, 7'd2}); end
        checks++; if (colours !== EXP_ERASE) begin errors++; $display("FAIL erase_colour got %h exp %h", colours, EXP_ERASE); end
    endtask

    task automatic test_out_of_range;
        int strobes;
        do_reset();
        set_src(0, 200, 5, 9'h001, 1'b0);
        src_valid = 4'b0001;
        #1;
        checks++; if (src_ready !== 4'b0001) begin errors++; $display("FAIL oor_ready0 got %b exp 0001", src_ready); end
        @(negedge clk);
        set_src(0, 5, 127, 9'h002, 1'b0);
        #1;
        checks++; if (src_ready !== 4'b0001) begin errors++; $display("FAIL oor_ready1 got %b exp 0001", src_ready); end
        @(negedge clk);
        set_src(0, 159, 119, 9'h0F0, 1'b0);
        @(negedge clk);
        set_src(0, 160, 0, 9'h003, 1'b0);
        #1;
        checks++; if (VGA_write_enable !== 1'b0) begin errors++; $display("FAIL oor_we_x got %b exp 0", VGA_write_enable); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL oor_drop1 got %0d exp 1", drop_count); end
        @(negedge clk);
        src_valid = '0;
        #1;
        checks++; if (VGA_write_enable !== 1'b0) begin errors++; $display("FAIL oor_we_y got %b exp 0", VGA_write_enable); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL oor_drop2 got %0d exp 2", drop_count); end
        @(negedge clk);
        checks++; if (VGA_write_enable !== 1'b1) begin errors++; $display("FAIL edge_we got %b exp 1", VGA_write_enable); end
        checks++; if (coordinates !== {8'd159, 7'd119}) begin errors++; $display("FAIL edge_coord got %h exp %h", coordinates, {8'd159, 7'd119}); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL edge_drop got %0d exp 2", drop_count); end
        @(negedge clk);
        checks++; if (VGA_write_enable !== 1'b0) begin errors++; $display("FAIL oor_we_x160 got %b exp 0", VGA_write_enable); end
        checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL oor_drop3 got %0d exp 3", drop_count); end
        set_src(0, 0, 120, 9'h004, 1'b0);
        src_valid = 4'b0001;
        strobes   = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (VGA_write_enable === 1'b1) strobes++;
        end
        src_valid = '0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (VGA_write_enable === 1'b1) strobes++;
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL sat_strobes got %0d exp 0", strobes); end
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_drop got %0d exp 255", drop_count); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        set_src(1, 30, 30, 9'h011, 1'b0);
        src_valid = 4'b0010;
        #1;
        checks++; if (src_ready !== 4'b0010) begin errors++; $display("FAIL mid_ready0 got %b exp 0010", src_ready); end
        @(negedge clk);
        set_src(2, 31, 31, 9'h022, 1'b0);
        src_valid = 4'b0100;
        #1;
        checks++; if (src_ready !== 4'b0100) begin errors++; $display("FAIL mid_ready1 got %b exp 0100", src_ready); end
        @(negedge clk);
        src_valid = '0;
        resetn    = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
        @(negedge clk);
        resetn = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after got %b exp 0", busy); end
        checks++; if (VGA_write_enable !== 1'b0) begin errors++; $display("FAIL mid_we0 got %b exp 0", VGA_write_enable); end
        for (int n = 1; n < 3; n++) begin
            @(negedge clk);
            checks++; if (VGA_write_enable !== 1'b0) begin errors++; $display("FAIL mid_we%0d got %b exp 0", n, VGA_write_enable); end
        end
        set_src(1, 40, 40, 9'h033, 1'b0);
        set_src(3, 41, 41, 9'h044, 1'b0);
        src_valid = 4'b1010;
        #1;
        checks++; if (src_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr_restart got %b exp 0010", src_ready); end
        src_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_sparse;
        do_reset();
        set_src(3, 50, 1, 9'h0C3, 1'b0);
        src_valid = 4'b1000;
        #1;
        checks++; if (src_ready !== 4'b1000) begin errors++; $display("FAIL sparse_ready3 got %b exp 1000", src_ready); end
        @(negedge clk);
        set_src(1, 51, 2, 9'h0C1, 1'b0);
        src_valid = 4'b0010;
        #1;
        checks++; if (src_ready !== 4'b0010) begin errors++; $display("FAIL sparse_wrap got %b exp 0010", src_ready); end
        @(negedge clk);
        set_src(2, 52, 3, 9'h0C2, 1'b0);
        src_valid = 4'b0110;
        #1;
        checks++; if (src_ready !== 4'b0100) begin errors++; $display("FAIL sparse_ptr2 got %b exp 0100", src_ready); end
        @(negedge clk);
        src_valid = '0;
        #1;
        checks++; if (coordinates !== {8'd50, 7'd1} || VGA_write_enable !== 1'b1) begin errors++; $display("FAIL sparse_out3 got %h/%b exp %h/1", coordinates, VGA_write_enable, {8'd50, 7'd1}); end
        @(negedge clk);
        checks++; if (coordinates !== {8'd51, 7'd2} || colours !== 9'h0C1) begin errors++; $display("FAIL sparse_out1 got %h/%h exp %h/0c1", coordinates, colours, {8'd51, 7'd2}); end
        @(negedge clk);
        checks++; if (coordinates !== {8'd52, 7'd3} || colours !== 9'h0C2) begin errors++; $display("FAIL sparse_out2 got %h/%h exp %h/0c2", coordinates, colours, {8'd52, 7'd3}); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sparse_idle_busy got %b exp 0", busy); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_erase();
        test_out_of_range();
        test_reset_mid();
        test_sparse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
